// File: rtl/fpu_div_seq.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division,
// one quotient bit per clock, then normalise, round half-up and saturate/flush.
module fpu_div_seq #(
  parameter int SIZE_DATA = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [SIZE_DATA-1:0] i_32_a,
  input  logic [SIZE_DATA-1:0] i_32_b,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [SIZE_DATA-1:0] o_32_div
);

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t state, state_nxt;

  logic              start_acc;
  logic              a_zero, b_zero;
  logic signed [9:0] exp_a_s, exp_b_s;

  logic              sign_p0;
  logic [23:0]       mb_p0;
  logic signed [9:0] exp_p0;

  logic [25:0]       q_p1;
  logic [25:0]       rem_p1;
  logic [4:0]        cnt_p1;
  logic              rem_ge;
  logic [25:0]       rem_diff;

  logic [31:0]       res_p2;

  function automatic logic [31:0] special_res(input logic sign, input logic div_zero);
    if (div_zero) return {sign, 8'hFF, 23'h0};
    return {sign, 31'h0};
  endfunction

  // Normalise the 26-bit quotient, round half-up, then saturate or flush.
  function automatic logic [31:0] round_norm(input logic sign, input logic [25:0] q,
                                             input logic signed [9:0] e);
    logic [24:0]       man;
    logic              rnd;
    logic signed [9:0] ex;
    if (q[25]) begin
      man = {1'b0, q[25:2]};
      rnd = q[1];
      ex  = e;
    end else begin
      man = {1'b0, q[24:1]};
      rnd = q[0];
      ex  = e - 10'sd1;
    end
    man = man + {24'd0, rnd};
    if (man[24]) begin
      man = 25'h0800000;
      ex  = ex + 10'sd1;
    end
    if (ex >= 10'sd255) return {sign, 8'hFF, 23'h0};
    if (ex <= 10'sd0)   return {sign, 31'h0};
    return {sign, ex[7:0], man[22:0]};
  endfunction

  assign start_acc = (state == IDLE) && i_start;
  assign a_zero    = (i_32_a[30:23] == 8'd0);
  assign b_zero    = (i_32_b[30:23] == 8'd0);
  assign exp_a_s   = $signed({2'b00, i_32_a[30:23]});
  assign exp_b_s   = $signed({2'b00, i_32_b[30:23]});
  assign o_ready   = (state == IDLE);

  assign rem_ge   = (rem_p1 >= {2'b00, mb_p0});
  assign rem_diff = rem_p1 - {2'b00, mb_p0};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_start) state_nxt = (a_zero || b_zero) ? DONE : CALC;
      CALC: if (cnt_p1 == 5'd25) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: control, quotient/remainder iteration and output register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      q_p1     <= '0;
      rem_p1   <= '0;
      cnt_p1   <= '0;
      o_valid  <= 1'b0;
      o_32_div <= '0;
    end else begin
      state   <= state_nxt;
      o_valid <= (state == DONE);
      if (state == DONE) o_32_div <= res_p2;
      if (start_acc) begin
        q_p1   <= '0;
        rem_p1 <= {3'b001, i_32_a[22:0]};
        cnt_p1 <= '0;
      end else if (state == CALC) begin
        q_p1   <= {q_p1[24:0], rem_ge};
        rem_p1 <= rem_ge ? {rem_diff[24:0], 1'b0} : {rem_p1[24:0], 1'b0};
        cnt_p1 <= cnt_p1 + 5'd1;
      end
    end
  end

  // Stage p0/p2: captured operands and the pending result
  always_ff @(posedge i_clk) begin
    if (start_acc) begin
      sign_p0 <= i_32_a[31] ^ i_32_b[31];
      mb_p0   <= {1'b1, i_32_b[22:0]};
      exp_p0  <= exp_a_s - exp_b_s + 10'sd127;
      res_p2  <= special_res(i_32_a[31] ^ i_32_b[31], b_zero);
    end else if (state == NORM) begin
      res_p2  <= round_norm(sign_p0, q_p1, exp_p0);
    end
  end

endmodule

// File: tb/tb_fpu_div_seq.sv
// Bench for fpu_div_seq: directed cases plus randomized divides, checked every
// cycle against an arithmetic reference model with a latency/handshake model.
module tb_fpu_div_seq;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_32_a  = 32'h0;
  logic [31:0] i_32_b  = 32'h0;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_32_div;

  int checks = 0;
  int errors = 0;

  logic        chk_en    = 1'b0;
  logic        m_busy    = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_out   = 32'h0;
  logic [31:0] pend      = 32'h0;
  int          edges     = 0;
  int          due       = 0;

  always #5 i_clk = ~i_clk;

  fpu_div_seq #(.SIZE_DATA(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_32_a  (i_32_a),
    .i_32_b  (i_32_b),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_32_div(o_32_div)
  );

  function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
  endfunction

  // Quotient from integer division, then normalise/round/clamp as stated.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, q, man, rnd;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (eb == 0) return {s, 8'hFF, 23'h0};
    if (ea == 0) return {s, 31'h0};
    ma = longint'(a[22:0]) + (longint'(1) << 23);
    mb = longint'(b[22:0]) + (longint'(1) << 23);
    q  = (ma << 25) / mb;
    e  = ea - eb + 127;
    if (q >= (longint'(1) << 25)) begin
      man = q >> 2;
      rnd = longint'(q[1]);
    end else begin
      man = q >> 1;
      rnd = longint'(q[0]);
      e   = e - 1;
    end
    man = man + rnd;
    if (man == (longint'(1) << 24)) begin
      man = longint'(1) << 23;
      e   = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], man[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int          r;
    v = $urandom;
    r = $urandom_range(0, 15);
    case (r)
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFE;
      2: v[30:23] = 8'h01;
      3: v[22:0]  = 23'h0;
      4: v[22:0]  = 23'h7FFFFF;
      5: v[30:23] = 8'h7F;
      default: ;
    endcase
    return v;
  endfunction

  // Transaction model: accepted start at edge n -> result, valid after edge n+L.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_busy    <= 1'b0;
      exp_valid <= 1'b0;
      exp_out   <= 32'h0;
    end else begin
      edges     <= edges + 1;
      exp_valid <= 1'b0;
      if (m_busy && edges == due) begin
        m_busy    <= 1'b0;
        exp_valid <= 1'b1;
        exp_out   <= pend;
      end else if (!m_busy && i_start) begin
        m_busy <= 1'b1;
        pend   <= ref_div(i_32_a, i_32_b);
        due    <= edges + (is_special(i_32_a, i_32_b) ? 1 : 28);
      end
    end
  end

  task automatic monitor();
    forever begin
      @(negedge i_clk);
      if (chk_en) begin
        checks++;
        if (o_valid !== exp_valid) begin
          errors++;
          if (errors < 50) $display("FAIL mon_valid t=%0t got %b want %b", $time, o_valid, exp_valid);
        end
        checks++;
        if (o_ready !== !m_busy) begin
          errors++;
          if (errors < 50) $display("FAIL mon_ready t=%0t got %b want %b", $time, o_ready, !m_busy);
        end
        checks++;
        if (o_32_div !== exp_out) begin
          errors++;
          if (errors < 50) $display("FAIL mon_div t=%0t got %h want %h", $time, o_32_div, exp_out);
        end
      end
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (o_ready !== 1'b1 && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got %b want 1", o_ready);
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want,
                       input int lat, input string name, input bit hold);
    int          k;
    bit          got;
    logic [31:0] res;
    wait_ready();
    i_32_a  = a;
    i_32_b  = b;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    if (!hold) i_start = 1'b0;
    k   = 0;
    got = 1'b0;
    res = 32'h0;
    while (k < 60) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) begin
        got = 1'b1;
        res = o_32_div;
        break;
      end
      if (hold) begin
        i_32_a = $urandom;
        i_32_b = $urandom;
      end
      k++;
    end
    i_start = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout got no valid want valid", name);
    end else begin
      check32(name, res, want);
      checks++;
      if (k != lat) begin
        errors++;
        $display("FAIL %s_latency got %0d want %0d", name, k, lat);
      end
    end
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) cnt++;
    end
  endtask

  initial begin
    int          nv;
    logic [31:0] a, b;
    fork
      monitor();
    join_none

    repeat (2) @(posedge i_clk);
    #1;
    chk_en = 1'b1;
    @(negedge i_clk);
    check32("rst_ready", {31'h0, o_ready}, 32'h1);
    check32("rst_valid", {31'h0, o_valid}, 32'h0);
    check32("rst_div", o_32_div, 32'h0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    check32("model_6_2", ref_div(32'h40C00000, 32'h40000000), 32'h40400000);
    check32("model_1_3", ref_div(32'h3F800000, 32'h40400000), 32'h3EAAAAAB);
    check32("model_ovf", ref_div(32'h7F000000, 32'h3E800000), 32'h7F800000);

    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 28, "six_by_two", 1'b0);
    do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, "one_by_three", 1'b0);
    do_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1, "div_zero", 1'b0);
    do_op(32'h80000000, 32'h3F800000, 32'h80000000, 1, "zero_num", 1'b0);
    do_op(32'hC0000000, 32'h3F800000, 32'hC0000000, 28, "neg_sign", 1'b0);
    do_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 28, "overflow", 1'b0);
    do_op(32'h00000000, 32'h80000000, 32'hFF800000, 1, "zero_by_zero", 1'b0);

    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 28, "held_start", 1'b1);
    count_valids(40, nv);
    check32("held_single_valid", nv, 0);

    wait_ready();
    i_32_a  = 32'h3F800000;
    i_32_b  = 32'h40400000;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check32("abort_valid", {31'h0, o_valid}, 32'h0);
    check32("abort_ready", {31'h0, o_ready}, 32'h1);
    check32("abort_div", o_32_div, 32'h0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    count_valids(40, nv);
    check32("abort_no_valid", nv, 0);
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 28, "after_abort", 1'b0);

    for (int i = 0; i < 150; i++) begin
      a = rand_fp();
      b = rand_fp();
      do_op(a, b, ref_div(a, b), is_special(a, b) ? 1 : 28, "rand", ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge i_clk);
      #1;
    end

    repeat (3) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
